// File: rtl/spi_pkg.sv
// Shared definitions for the SPI host master and the slave-side timing models.
package spi_pkg;

    localparam int SPI_DATA_W_DEFAULT   = 8;
    localparam int SPI_CLK_HALF_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DONE,
        WAIT_NEXT,
        TRAIL,
        GUARD
    } spi_state_e;

endpackage

// File: rtl/spi_half_timer.sv
// SCK half-period timer: counts 0..CLK_HALF-1 and strobes phase_end on the last count.
module spi_half_timer
    import spi_pkg::*;
#(
    parameter int CLK_HALF = SPI_CLK_HALF_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic phase_end
);

    localparam int CNT_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;

    logic [CNT_W-1:0] cnt;

    assign phase_end = (cnt == CNT_W'(CLK_HALF - 1));

    // Free-running half-period count, wrapping on phase end and held at zero while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// SPI mode-0 initiator: byte-wide command/response handshake with chip select held across bursts.
module spi_host_master
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W_DEFAULT,
    parameter int CLK_HALF = SPI_CLK_HALF_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              ss_n
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    spi_state_e        state;
    spi_state_e        state_next;
    logic              phase_end;
    logic              accept;
    logic              last_bit;
    logic              last_q;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [BIT_W-1:0]  bit_cnt;

    assign cmd_ready = (state == IDLE) || (state == WAIT_NEXT);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);
    assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));
    assign mosi      = tx_shift[DATA_W-1];

    // The timer idles at zero while waiting for a byte, so every transfer starts on a fresh half period.
    // It keeps running through DONE, so the trail time is measured from the last SCK fall.
    spi_half_timer #(
        .CLK_HALF (CLK_HALF)
    ) u_half_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (cmd_ready),
        .phase_end (phase_end)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: SCK phases advance on phase_end, DONE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, WAIT_NEXT: if (accept)    state_next = SETUP;
            SETUP:           if (phase_end) state_next = HIGH;
            HIGH:            if (phase_end) state_next = last_bit ? DONE : LOW;
            LOW:             if (phase_end) state_next = HIGH;
            DONE:                           state_next = last_q ? TRAIL : WAIT_NEXT;
            TRAIL:           if (phase_end) state_next = GUARD;
            GUARD:           if (phase_end) state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // Shift datapath and SPI pins: MISO is captured on SCK rise, MOSI moves on SCK fall or on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck      <= 1'b0;
            ss_n     <= 1'b1;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            last_q   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE, WAIT_NEXT: begin
                    if (accept) begin
                        tx_shift <= cmd_data;
                        last_q   <= cmd_last;
                        ss_n     <= 1'b0;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], miso};
                        bit_cnt  <= '0;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        sck <= 1'b0;
                        if (!last_bit) begin
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[DATA_W-2:0], miso};
                    end
                end
                DONE: begin
                    rx_valid <= 1'b1;
                    rx_data  <= rx_shift;
                end
                TRAIL: begin
                    if (phase_end) begin
                        ss_n <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_host_master.sv
// Bench for spi_host_master: memory-style SPI slave model on an 8-bit/CLK_HALF=2 instance
// plus a 16-bit/CLK_HALF=1 instance with MISO looped back to MOSI.
module tb_spi_host_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_data;
    logic        cmd_last;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        busy;
    logic        sck;
    logic        mosi;
    logic        miso = 1'b0;
    logic        ss_n;

    logic        cmd_valid1;
    logic        cmd_ready1;
    logic [15:0] cmd_data1;
    logic        cmd_last1;
    logic        rx_valid1;
    logic [15:0] rx_data1;
    logic        busy1;
    logic        sck1;
    logic        mosi1;
    logic        ss_n1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] ref_mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    spi_host_master #(.DATA_W(8), .CLK_HALF(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_last(cmd_last), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    spi_host_master #(.DATA_W(16), .CLK_HALF(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_data(cmd_data1), .cmd_last(cmd_last1), .rx_valid(rx_valid1), .rx_data(rx_data1),
        .busy(busy1), .sck(sck1), .mosi(mosi1), .miso(mosi1), .ss_n(ss_n1)
    );

    // Slave model: cmd 0x02 = write (addr, data...), 0x03 = read (addr, data...); otherwise answers 0x3C.
    logic [7:0] s_mem [256];
    logic [7:0] s_resp = 8'h3C;
    logic [7:0] s_rcv = 8'h00;
    logic [7:0] s_cmd = 8'h00;
    logic [7:0] s_ptr = 8'h00;
    int         s_bits = 0;
    int         s_idx = 0;
    bit         s_init = 1'b0;
    logic       s_prev_sck = 1'b0;
    logic       s_prev_ssn = 1'b1;

    always @(negedge clk) begin
        if (!s_init) begin
            for (int i = 0; i < 256; i++) s_mem[i] = 8'(i) ^ 8'h5A;
            s_init = 1'b1;
        end
        if (!ss_n && s_prev_ssn) begin
            s_idx  = 0;
            s_bits = 0;
            s_resp = 8'h3C;
            miso   = s_resp[7];
        end else if (ss_n) begin
            s_idx  = 0;
            s_bits = 0;
        end else begin
            if (sck && !s_prev_sck) begin
                s_rcv  = {s_rcv[6:0], mosi};
                s_bits = s_bits + 1;
                if (s_bits == 8) begin
                    case (s_idx)
                        0: s_cmd = s_rcv;
                        1: s_ptr = s_rcv;
                        default: begin
                            if (s_cmd == 8'h02) s_mem[s_ptr] = s_rcv;
                            s_ptr = s_ptr + 8'd1;
                        end
                    endcase
                    s_idx = s_idx + 1;
                end
            end
            if (!sck && s_prev_sck) begin
                if (s_bits == 8) begin
                    s_bits = 0;
                    s_resp = (s_idx >= 2 && s_cmd == 8'h03) ? s_mem[s_ptr] : 8'h3C;
                    miso   = s_resp[7];
                end else begin
                    miso = s_resp[3'(7 - s_bits)];
                end
            end
        end
        s_prev_sck = sck;
        s_prev_ssn = ss_n;
    end

    // Bus monitor: MOSI bytes at SCK rises, chip-select/busy edge times and handshake legality.
    logic [7:0] mosi_log [64];
    int         mosi_n = 0;
    logic [7:0] cur_byte = 8'h00;
    int         bit_n = 0;
    int         burst_rises = 0;
    int         last_burst_rises = 0;
    int         last_fall_cyc = 0;
    int         ssn_rise_cyc = 0;
    int         busy_fall_cyc = 0;
    int         ready_err = 0;
    int         sck_ssn_err = 0;
    int         outst = 0;
    bit         acc_last = 1'b0;
    bit         in_trail = 1'b0;
    bit         exp_ready;
    logic       m_prev_sck = 1'b0;
    logic       m_prev_ssn = 1'b1;
    logic       m_prev_busy = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bit_n       = 0;
            outst       = 0;
            in_trail    = 1'b0;
            burst_rises = 0;
        end else begin
            if (sck && !m_prev_sck) begin
                cur_byte    = {cur_byte[6:0], mosi};
                bit_n       = bit_n + 1;
                burst_rises = burst_rises + 1;
                if (bit_n == 8) begin
                    mosi_log[mosi_n % 64] = cur_byte;
                    mosi_n = mosi_n + 1;
                    bit_n  = 0;
                end
            end
            if (!sck && m_prev_sck) last_fall_cyc = cyc;
            if (!ss_n && m_prev_ssn) burst_rises = 0;
            if (ss_n && !m_prev_ssn) begin
                ssn_rise_cyc     = cyc;
                last_burst_rises = burst_rises;
            end
            if (!busy && m_prev_busy) busy_fall_cyc = cyc;
            if (sck && ss_n) sck_ssn_err = sck_ssn_err + 1;
            if (rx_valid) begin
                outst = outst - 1;
                if (acc_last) in_trail = 1'b1;
            end
            if (!busy) in_trail = 1'b0;
            exp_ready = (outst == 0) && (!busy || (!ss_n && !in_trail));
            if (cmd_ready !== exp_ready) ready_err = ready_err + 1;
            if (cmd_valid && cmd_ready) begin
                outst    = outst + 1;
                acc_last = cmd_last;
            end
        end
        m_prev_sck  = sck;
        m_prev_ssn  = ss_n;
        m_prev_busy = busy;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitRx(input int acc, output logic [7:0] rx, output int lat);
        bit got = 1'b0;
        rx  = 8'hxx;
        lat = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (rx_valid) begin
                got = 1'b1;
                rx  = rx_data;
                lat = cyc - acc;
            end
        end
        checkOutput("rx_seen", 32'(got), 32'd1);
        @(negedge clk);
        checkOutput("rx_valid_pulse", 32'(rx_valid), 32'd0);
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic last, output logic [7:0] rx, output int lat);
        bit ok = 1'b0;
        int acc = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_last  = last;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok  = 1'b1;
                acc = cyc + 1;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("accept_seen", 32'(ok), 32'd1);
        waitRx(acc, rx, lat);
    endtask

    task automatic waitIdle();
        bit idle = 1'b0;
        for (int k = 0; k < 400 && !idle; k++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        checkOutput("idle_seen", 32'(idle), 32'd1);
        @(negedge clk); #1;
    endtask

    initial begin
        logic [7:0]  rx;
        logic [7:0]  base;
        logic [7:0]  wdat [4];
        logic [7:0]  d2;
        logic [15:0] rx16;
        int          lat;
        int          rd;
        int          burst_len;
        int          acc1;
        int          acc2;
        int          rises;
        int          r1;
        int          r2;
        int          rx_cnt;
        bit          ok;
        bit          got;
        logic        prev;

        vecs[0] = '{8'hA5, 1'b1, 8'h3C};
        vecs[1] = '{8'h03, 1'b0, 8'h3C};
        vecs[2] = '{8'h00, 1'b0, 8'h3C};
        vecs[3] = '{8'h10, 1'b1, 8'h5A};
        vecs[4] = '{8'h02, 1'b0, 8'h3C};
        vecs[5] = '{8'h07, 1'b0, 8'h3C};
        vecs[6] = '{8'hC3, 1'b1, 8'h3C};
        vecs[7] = '{8'h03, 1'b0, 8'h3C};
        vecs[8] = '{8'h07, 1'b0, 8'h3C};
        vecs[9] = '{8'h00, 1'b1, 8'hC3};
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_data   = 8'h00;
        cmd_last   = 1'b0;
        cmd_valid1 = 1'b0;
        cmd_data1  = 16'h0000;
        cmd_last1  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_sck", 32'(sck), 32'd0);
        checkOutput("rst_ss_n", 32'(ss_n), 32'd1);
        checkOutput("rst_mosi", 32'(mosi), 32'd0);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Table-driven single byte, burst read, write and read-back.
        burst_len = 0;
        for (int i = 0; i < 10; i++) begin
            rd = mosi_n;
            applyStimulus(vecs[i].data, vecs[i].last, rx, lat);
            burst_len++;
            checkOutput($sformatf("vec%0d_rx_data", i), 32'(rx), 32'(vecs[i].exp_rx));
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd33);
            checkOutput($sformatf("vec%0d_mosi", i), 32'(mosi_log[rd % 64]), 32'(vecs[i].data));
            if (vecs[i].last) begin
                waitIdle();
                checkOutput($sformatf("vec%0d_sck_rises", i), 32'(last_burst_rises), 32'(8 * burst_len));
                if (i == 0) begin
                    checkOutput("ssn_after_last_fall", 32'(ssn_rise_cyc - last_fall_cyc), 32'd2);
                    checkOutput("busy_after_ssn_rise", 32'(busy_fall_cyc - ssn_rise_cyc), 32'd2);
                end
                burst_len = 0;
            end
        end
        ref_mem[7] = 8'hC3;

        // Back-pressure: cmd_valid held with changing data across the first byte.
        rd = mosi_n;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = 8'h11;
        cmd_last  = 1'b0;
        ok = 1'b0;
        acc1 = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok   = 1'b1;
                acc1 = cyc + 1;
            end
        end
        checkOutput("bp_first_accept", 32'(ok), 32'd1);
        ok = 1'b0;
        acc2 = 0;
        d2 = 8'h00;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk); #1;
            cmd_data = 8'($urandom);
            cmd_last = 1'b1;
            @(negedge clk);
            if (cmd_ready) begin
                ok   = 1'b1;
                acc2 = cyc + 1;
                d2   = cmd_data;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checkOutput("bp_second_accept", 32'(ok), 32'd1);
        checkOutput("bp_accept_spacing", 32'(acc2 - acc1), 32'd34);
        waitRx(acc2, rx, lat);
        checkOutput("bp_latency", 32'(lat), 32'd33);
        checkOutput("bp_mosi_first", 32'(mosi_log[rd % 64]), 32'h11);
        checkOutput("bp_mosi_second", 32'(mosi_log[(rd + 1) % 64]), 32'(d2));
        waitIdle();

        // Randomized write then read-back through the slave memory, against the bench memory model.
        for (int t = 0; t < 3; t++) begin
            base = 8'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) wdat[k] = 8'($urandom);
            applyStimulus(8'h02, 1'b0, rx, lat);
            applyStimulus(base, 1'b0, rx, lat);
            for (int k = 0; k < 4; k++) begin
                applyStimulus(wdat[k], 1'(k == 3), rx, lat);
                ref_mem[8'(base + 8'(k))] = wdat[k];
            end
            waitIdle();
            applyStimulus(8'h03, 1'b0, rx, lat);
            applyStimulus(base, 1'b0, rx, lat);
            for (int k = 0; k < 4; k++) begin
                applyStimulus(8'h00, 1'(k == 3), rx, lat);
                checkOutput($sformatf("loop%0d_rd%0d", t, k), 32'(rx), 32'(ref_mem[8'(base + 8'(k))]));
            end
            waitIdle();
        end

        // Reset after the 4th SCK rise aborts the byte immediately.
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = 8'h96;
        cmd_last  = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rises = 0;
        prev  = 1'b0;
        for (int k = 0; k < 100 && rises < 4; k++) begin
            @(negedge clk);
            if (sck && !prev) rises++;
            prev = sck;
        end
        checkOutput("rst_mid_rises", 32'(rises), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_sck", 32'(sck), 32'd0);
        checkOutput("rst_mid_ss_n", 32'(ss_n), 32'd1);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        rx_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (rx_valid) rx_cnt++;
        end
        checkOutput("rst_mid_no_rx", 32'(rx_cnt), 32'd0);
        rd = mosi_n;
        applyStimulus(8'h5A, 1'b1, rx, lat);
        checkOutput("post_rst_rx", 32'(rx), 32'h3C);
        checkOutput("post_rst_latency", 32'(lat), 32'd33);
        checkOutput("post_rst_mosi", 32'(mosi_log[rd % 64]), 32'h5A);
        waitIdle();

        // 16-bit word with CLK_HALF=1 and MISO tied to MOSI.
        @(posedge clk); #1;
        cmd_valid1 = 1'b1;
        cmd_data1  = 16'hBEEF;
        cmd_last1  = 1'b1;
        ok = 1'b0;
        acc1 = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (cmd_ready1) begin
                ok   = 1'b1;
                acc1 = cyc + 1;
            end
        end
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        checkOutput("w16_accept", 32'(ok), 32'd1);
        prev  = 1'b0;
        rises = 0;
        r1    = -1;
        r2    = -1;
        got   = 1'b0;
        lat   = -1;
        rx16  = 16'h0000;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (sck1 && !prev) begin
                rises++;
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            prev = sck1;
            if (rx_valid1) begin
                got  = 1'b1;
                lat  = cyc - acc1;
                rx16 = rx_data1;
            end
        end
        checkOutput("w16_rx_seen", 32'(got), 32'd1);
        checkOutput("w16_rx_data", 32'(rx16), 32'hBEEF);
        checkOutput("w16_latency", 32'(lat), 32'd33);
        checkOutput("w16_sck_period", 32'(r2 - r1), 32'd2);
        checkOutput("w16_sck_rises", 32'(rises), 32'd16);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (!busy1) ok = 1'b1;
        end
        checkOutput("w16_idle", 32'(ok), 32'd1);
        checkOutput("w16_ss_n_idle", 32'(ss_n1), 32'd1);

        checkOutput("cmd_ready_legality", 32'(ready_err), 32'd0);
        checkOutput("sck_high_with_ss_n_high", 32'(sck_ssn_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
- SPI mode-0 initiator driven from AXI-side register logic (slv_reg/slv_read words) in the axi_clk domain.
- Opposite end of the SPI link served by spi_slave. Lets software run byte transfers against the on-chip SPI memory, or external SPI parts, without the block-design SPI core.
- Byte-wide command/response handshake. Supports multi-byte bursts with chip-select held low between bytes.

Parameters:
- DATA_W, 8, bits per transfer; MSB first.
- CLK_HALF, 4, clk cycles per SCK half-period; must be >= 1.

Ports:
- clk  in  1  system clock (axi_clk)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  byte to send is presented
- cmd_ready  out  1  block can accept a byte
- cmd_data  in  DATA_W  byte to shift out on MOSI
- cmd_last  in  1  release ss_n after this byte
- rx_valid  out  1  one-cycle pulse: rx_data holds the captured byte
- rx_data  out  DATA_W  byte captured from MISO
- busy  out  1  high whenever ss_n is low or the guard time is running
- sck  out  1  SPI clock; idles low
- mosi  out  1  SPI data out
- miso  in  1  SPI data in; sampled directly, no synchroniser
- ss_n  out  1  chip select, active low

Behaviour:
- Reset values (async assert, sync release): state IDLE, sck=0, ss_n=1, mosi=0, cmd_ready=1, rx_valid=0, rx_data=0, busy=0. Reset mid-transfer aborts immediately; no rx_valid is produced.
- Accept: cmd_valid && cmd_ready on a rising clk edge. cmd_ready is high only in IDLE and WAIT_NEXT. Otherwise cmd_valid is held off and the data is not sampled.
- On accept: load tx shift register from cmd_data and latch cmd_last. ss_n<=0, mosi<=cmd_data[DATA_W-1], half-period counter<=0, go to SETUP.
- Half-period counter: counts 0..CLK_HALF-1. A phase ends when it reaches CLK_HALF-1, then it clears.
- SETUP: at phase end, sck<=1, sample miso into rx shift LSB, bit counter=0, go to HIGH.
- HIGH: at phase end, sck<=0.
  - If bit counter==DATA_W-1: go to DONE.
  - Otherwise: shift tx register, mosi<=next bit, bit counter+1, go to LOW.
- LOW: at phase end, sck<=1, sample miso, go to HIGH.
- Sampling and shifting: miso is sampled only on the sck rise. mosi changes only on the sck fall or on accept.
- DONE (1 cycle): rx_valid=1 and rx_data<=rx shift register.
  - If cmd_last was latched: go to TRAIL.
  - Otherwise: go to WAIT_NEXT.
- rx_valid timing: asserted exactly 2*DATA_W*CLK_HALF+1 clk cycles after the accept edge.
- WAIT_NEXT: ss_n stays 0, sck stays 0, cmd_ready=1. No timeout. Accept goes to SETUP, same as from IDLE.
- TRAIL: wait CLK_HALF cycles, then ss_n<=1 and go to GUARD.
- GUARD: wait CLK_HALF cycles with ss_n high, then go to IDLE. This gives a minimum ss_n high time of CLK_HALF.
- busy = (state != IDLE).
- cmd_valid in the same cycle as DONE is not accepted; cmd_ready=0 in DONE. It is accepted the next cycle in WAIT_NEXT or later in IDLE.
- CLK_HALF=1: sck toggles every clk; all phase rules are unchanged.
- Exactly DATA_W sck rising edges per byte. sck is never high while ss_n is high.

Decomposition:
- Shared package spi_pkg holds:
  - state enum: IDLE, SETUP, HIGH, LOW, DONE, WAIT_NEXT, TRAIL, GUARD
  - SPI_DATA_W_DEFAULT=8
  - SPI_CLK_HALF_DEFAULT=4
- Sub-module spi_half_timer: counter plus phase_end strobe, parameterised by CLK_HALF, with clear input. It is shared later with slave-side timing models.
- Everything else stays in one module.

Test Plan:
- Single byte, CLK_HALF=2.
  - Stimulus: send 0xA5 with cmd_last=1; miso model returns 0x3C.
  - Required: mosi at the 8 rising sck edges = 1,0,1,0,0,1,0,1; rx_valid pulse 33 cycles after accept with rx_data=0x3C.
  - Required: ss_n high 2 cycles after the last sck fall, then busy drops 2 cycles later.
- 3-byte burst.
  - Stimulus: 0x03, 0x00, 0x10 with cmd_last only on the third byte.
  - Required: ss_n continuously low across all bytes; 24 sck rises; three rx_valid pulses; cmd_ready low except in IDLE/WAIT_NEXT.
- Loopback with spi_slave on the same clk.
  - Stimulus: write a byte sequence, then read it back with the slave's command bytes.
  - Required: read data equals the written data.
- Back-pressure.
  - Stimulus: hold cmd_valid with changing cmd_data during a transfer.
  - Required: no accept until WAIT_NEXT; the transmitted byte equals the cmd_data present at the accept edge.
- Reset mid-transfer.
  - Stimulus: assert rst_n low after the 4th sck rise.
  - Required: same cycle (async) sck=0, ss_n=1, busy=0, no rx_valid; a fresh transfer after release is correct.
- CLK_HALF=1, DATA_W=16.
  - Stimulus: send 0xBEEF, miso looped to mosi.
  - Required: rx_data=0xBEEF 33 cycles after accept; sck period = 2 clk.
